// File: rtl/onchip_mem_port2_arbiter.sv
// onchip_mem_port2_arbiter: round-robin two-master burst arbiter for on-chip memory port s2
module onchip_mem_port2_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int BE_W    = 4,
    parameter int DEPTH   = 50000,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  m0_address,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [BE_W-1:0]    m0_byteenable,
    input  logic [DATA_W-1:0]  m0_writedata,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,
    input  logic [ADDR_W-1:0]  m1_address,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [BE_W-1:0]    m1_byteenable,
    input  logic [DATA_W-1:0]  m1_writedata,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BE_W-1:0]    mem_byteenable,
    output logic               mem_chipselect,
    output logic               mem_write,
    output logic [DATA_W-1:0]  mem_writedata,
    input  logic [DATA_W-1:0]  mem_readdata
);
    localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2;
    logic [1:0] state;
    logic owner, ptr, mem_own, rv_valid, rv_owner;
    logic [ADDR_W-1:0] addr, win_addr;
    logic [BURST_W-1:0] rem, win_bc;
    logic req0, req1, win, win_wr, own_wr, grant, beat_wr, wr_busy;
    logic [BE_W-1:0] win_be, own_be;
    logic [DATA_W-1:0] win_wd, own_wd;

    // Start addresses beyond DEPTH pass through once, then wrap to 0.
    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
        return (32'(a) >= DEPTH - 1) ? '0 : a + ADDR_W'(1);
    endfunction

    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        win = (req0 & req1) ? ptr : req1;
        win_addr = win ? m1_address : m0_address;
        win_bc = win ? m1_burstcount : m0_burstcount;
        win_wr = win ? m1_write : m0_write;
        win_be = win ? m1_byteenable : m0_byteenable;
        win_wd = win ? m1_writedata : m0_writedata;
        own_wr = owner ? m1_write : m0_write;
        own_be = owner ? m1_byteenable : m0_byteenable;
        own_wd = owner ? m1_writedata : m0_writedata;
        grant = !reset && state == IDLE && (req0 | req1);
        wr_busy = !reset && state == WR;
        beat_wr = wr_busy && own_wr;
        m0_waitrequest = !((grant && !win) || (wr_busy && !owner));
        m1_waitrequest = !((grant && win) || (wr_busy && owner));
        m0_readdatavalid = rv_valid && !rv_owner;
        m1_readdatavalid = rv_valid && rv_owner;
        m0_readdata = mem_readdata;
        m1_readdata = mem_readdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            ptr <= 1'b0;
            addr <= '0;
            rem <= '0;
            mem_address <= '0;
            mem_byteenable <= '0;
            mem_chipselect <= 1'b0;
            mem_write <= 1'b0;
            mem_writedata <= '0;
            mem_own <= 1'b0;
            rv_valid <= 1'b0;
            rv_owner <= 1'b0;
        end else begin
            // Return routing follows the owner of the beat on the port, not the current owner.
            rv_valid <= mem_chipselect && !mem_write;
            rv_owner <= mem_own;
            mem_chipselect <= 1'b0;
            mem_write <= 1'b0;
            if (grant) begin
                owner <= win;
                ptr <= !win;
                mem_own <= win;
                addr <= inc(win_addr);
                rem <= (win_bc == '0) ? '0 : win_bc - BURST_W'(1);
                mem_address <= win_addr;
                mem_chipselect <= 1'b1;
                mem_write <= win_wr;
                mem_byteenable <= win_wr ? win_be : '1;
                mem_writedata <= win_wd;
                state <= (win_bc > BURST_W'(1)) ? (win_wr ? WR : RD) : IDLE;
            end else if (state == RD || beat_wr) begin
                mem_own <= owner;
                addr <= inc(addr);
                rem <= rem - BURST_W'(1);
                mem_address <= addr;
                mem_chipselect <= 1'b1;
                mem_write <= beat_wr;
                mem_byteenable <= beat_wr ? own_be : '1;
                mem_writedata <= own_wd;
                if (rem == BURST_W'(1)) state <= IDLE;
            end
        end
    end
endmodule

// File: doc/onchip_mem_port2_arbiter.md
# onchip_mem_port2_arbiter

Two-master round-robin burst arbiter for the second port (s2) of the dual-port on-chip memory. It lets the audio sample writer (master 0) and the visualizer frame reader (master 1) share that port. Each master sees an Avalon-MM-style burst slave. The arbiter drives registered address, strobe and data onto the memory port, and routes the memory's one-cycle-latency read data back to the master that issued the read.

## Interface
Parameters:
- ADDR_W, 16, word-address width of the memory port
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- DEPTH, 50000, memory depth in words; the burst address counter wraps at this value
- BURST_W, 4, burstcount width; maximum burst is 2^BURST_W-1

Ports:
- clk  in  1  single clock for the block and the memory port
- reset  in  1  synchronous, active-high reset
- mN_address  in  ADDR_W  start word address (N = 0, 1, for each port below)
- mN_burstcount  in  BURST_W  beats in the burst; 0 is treated as 1
- mN_read / mN_write  in  1  request strobes
- mN_byteenable  in  BE_W  write byte lanes
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  high = command or beat not accepted
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  mN_readdata is valid this cycle
- mem_address  out  ADDR_W  registered memory address
- mem_byteenable  out  BE_W  registered byte lanes; all ones for reads
- mem_chipselect  out  1  registered access strobe
- mem_write  out  1  registered write enable
- mem_writedata  out  DATA_W  registered write data
- mem_readdata  in  DATA_W  memory q, valid one cycle after the address is presented

## Operation
- States:
  - IDLE: accept a command.
  - RD: issue the remaining read beats.
  - WR: accept the remaining write beats.
- IDLE:
  - A master requests when its read or write is high. Read and write both high is treated as a write.
  - Only one master requests: it wins.
  - Both request: the master selected by the priority pointer wins.
  - The winner gets waitrequest low in that same cycle; the loser stays high.
  - On acceptance, latch owner = winner, addr = address, rem = max(burstcount,1) - 1, and set the pointer to the other master.
  - The mem_* registers load the first beat.
  - rem == 0 → stay in IDLE; otherwise go to RD or WR.
- RD:
  - Each cycle: addr advances (wrap DEPTH-1 → 0), mem_* load a read of addr, rem decrements.
  - At rem == 0 after the load → IDLE.
  - mN_waitrequest stays high for both masters.
- WR:
  - The owner's waitrequest is low.
  - Each cycle with owner write high: accept the beat, load mem write of addr with the beat's data and byteenable, advance addr, decrement rem.
  - Owner write low: stall; mem_chipselect is 0 next cycle.
  - At rem reaching 0 → IDLE.
  - The non-owner's waitrequest stays high.
- Address counter: modulo DEPTH. A start address ≥ DEPTH is passed through unchanged for the first beat; the next increment wraps to 0.
- Read return:
  - A one-stage valid/owner pipeline follows each issued read.
  - mN_readdatavalid = pipeline valid and pipeline owner == N.
  - Both mN_readdata = mem_readdata.
- Reset, including mid-burst: state → IDLE, pointer → master 0, all mem_* = 0, readdatavalid pipeline cleared. In-flight beats are dropped. Both waitrequests are high while reset is high.

## Timing
- Reset values: mem_address 0, mem_byteenable 0, mem_chipselect 0, mem_write 0, mem_writedata 0, mN_readdatavalid 0, mN_waitrequest 1.
- Read command accepted in cycle T:
  - Beat k is on the memory port in cycle T+1+k.
  - mN_readdatavalid is high in cycle T+2+k.
  - A burst of B reads returns data in T+2 … T+1+B, with no gaps.
- Write beat accepted in cycle C: mem_write is high in cycle C+1.
- IDLE re-arbitrates in the cycle after the last beat is issued. Back-to-back single-beat commands sustain 1 access per cycle.
- Read data of a finished burst may return while a new command is accepted. Routing uses the pipelined owner, not the current owner.

## Test plan
- Reset, then m0 reads burst 4 at 0x0010 → mem_address 0x10..0x13 in T+1..T+4; m0_readdatavalid high T+2..T+5 with memory contents; m1 sees no valid.
- m0 and m1 both issue single writes every cycle from reset → grants alternate m0, m1, m0…; mem_write continuous; each master's waitrequest low every other cycle.
- m1 writes burst 3 at 0xC34F (DEPTH-1), stalling 2 cycles after beat 1 → mem addresses 0xC34F, 0x0000, 0x0001; mem_chipselect low for exactly 2 cycles.
- m0 reads burst 2, m1 reads burst 1 in the cycle after m0's last issue → m0 valid twice, then m1 valid once, consecutive, each with correct data.
- Reset asserted mid-way through an m0 read burst of 8 → all mem_* 0 and no readdatavalid in the following cycle; first command after reset goes to m0 when both request.
- burstcount 0 on a write → exactly one beat written; the block returns to IDLE.
